// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: oversampled line, mid-bit sampling, valid/ready byte output
// with one-cycle frame_error and overrun pulses.
module uart_rx_8n1 #(
    parameter int CLOCK_RATE_HZ = 100_000_000,
    parameter int BAUD_RATE     = 9_600,
    parameter int OVERSAMPLE    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] data,
    output logic       frame_error,
    output logic       overrun
);

    localparam int CLOCKS_PER_TICK = CLOCK_RATE_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W  = (CLOCKS_PER_TICK > 1) ? $clog2(CLOCKS_PER_TICK) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLOCKS_PER_TICK - 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

    if (CLOCKS_PER_TICK < 1) begin : g_bad_rate
        $error("uart_rx_8n1: CLOCK_RATE_HZ too low for BAUD_RATE * OVERSAMPLE");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_oversample
        $error("uart_rx_8n1: OVERSAMPLE must be even and >= 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state, state_next;

    logic              rx_p0;
    logic              rx_p1;
    logic              rx_prev;
    logic [1:0]        warm;
    logic              rx_s;
    logic              start_edge;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [TICK_W-1:0] tick_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;

    logic clear_ticks;
    logic bit_point;
    logic take_start;
    logic sample_bit;
    logic stop_ok;
    logic stop_bad;

    // stage p0/p1: two-flop synchronizer; rx_prev only trusts rx_s once the
    // synchronizer has refilled after reset, so a line already low is not a start
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_p0   <= 1'b1;
            rx_p1   <= 1'b1;
            rx_prev <= 1'b0;
            warm    <= 2'b00;
        end else begin
            rx_p0   <= rx;
            rx_p1   <= rx_p0;
            warm    <= {warm[0], 1'b1};
            rx_prev <= rx_p1 & warm[1];
        end
    end

    assign rx_s       = rx_p1;
    assign start_edge = rx_prev & ~rx_s;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clock) begin
        if (reset || clear_ticks || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_edge) state_next = S_START;
            S_START: if (tick && tick_cnt == HALF_LAST) state_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (tick && tick_cnt == FULL_LAST && bit_idx == 3'd7) state_next = S_STOP;
            S_STOP:  if (tick && tick_cnt == FULL_LAST) state_next = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        clear_ticks = 1'b0;
        bit_point   = 1'b0;
        take_start  = 1'b0;
        sample_bit  = 1'b0;
        stop_ok     = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            S_IDLE:  clear_ticks = start_edge;
            S_START: begin
                bit_point  = tick && (tick_cnt == HALF_LAST);
                take_start = bit_point && !rx_s;
            end
            S_DATA: begin
                bit_point  = tick && (tick_cnt == FULL_LAST);
                sample_bit = bit_point;
            end
            S_STOP: begin
                bit_point = tick && (tick_cnt == FULL_LAST);
                stop_ok   = bit_point && rx_s;
                stop_bad  = bit_point && !rx_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || clear_ticks || bit_point) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || take_start) begin
            bit_idx <= 3'd0;
        end else if (sample_bit) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (sample_bit) begin
            shift <= {rx_s, shift[7:1]};
        end
    end

    // output stage: delivery, handshake and error pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            valid       <= 1'b0;
            data        <= 8'h00;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= stop_bad;
            overrun     <= stop_ok && valid && !ready;
            if (stop_ok) begin
                if (!valid || ready) begin
                    data  <= shift;
                    valid <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1 at 16 clocks per bit; a scoreboard queue holds
// the bytes each frame should deliver and a monitor pops them as the DUT presents them.
module tb_uart_rx_8n1;

    localparam int BIT_CLKS = 16;

    logic       clock;
    logic       reset;
    logic       rx;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       frame_error;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int   cyc      = 0;
    int   rise_cyc = 0;
    int   nbytes   = 0;
    int   vcycles  = 0;
    int   fe_cnt   = 0;
    int   ov_cnt   = 0;
    logic valid_d  = 1'b0;
    logic acc_d    = 1'b0;

    uart_rx_8n1 #(
        .CLOCK_RATE_HZ(1_600_000),
        .BAUD_RATE    (100_000),
        .OVERSAMPLE   (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .valid      (valid),
        .ready      (ready),
        .data       (data),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A byte is newly presented when valid rises or is refilled in the accept cycle
    always @(negedge clock) begin
        if (reset) begin
            valid_d = 1'b0;
            acc_d   = 1'b0;
        end else begin
            if (valid && (!valid_d || acc_d)) begin
                nbytes++;
                rise_cyc = cyc;
                check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check("sb_data", 32'(data), 32'(mon_exp));
                end
            end
            if (valid)       vcycles++;
            if (frame_error) fe_cnt++;
            if (overrun)     ov_cnt++;
            valid_d = valid;
            acc_d   = valid && ready;
        end
    end

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            clks(BIT_CLKS);
        end
        rx = stop_bit;
        clks(BIT_CLKS);
    endtask

    task automatic accept_one();
        ready = 1'b1;
        clks(1);
        ready = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int t0, lat, nb0, fe0, ov0, vc0;
        logic [7:0] c3;

        reset = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        clks(5);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data", 32'(data), 32'h00);
        check("reset_fe", 32'(frame_error), 32'd0);
        check("reset_ov", 32'(overrun), 32'd0);
        reset = 1'b0;
        clks(20);

        // 1: latency, hold while ready low, release with one ready cycle
        exp_q.push_back(8'hA5);
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        lat = rise_cyc - t0;
        check("t1_latency_in_range", 32'(lat >= 152 && lat <= 156), 32'd1);
        check("t1_valid", 32'(valid), 32'd1);
        check("t1_data", 32'(data), 32'hA5);
        clks(50);
        check("t1_valid_hold", 32'(valid), 32'd1);
        check("t1_data_hold", 32'(data), 32'hA5);
        accept_one();
        check("t1_valid_drop", 32'(valid), 32'd0);

        // 2: short glitch then a real frame
        nb0 = nbytes;
        fe0 = fe_cnt;
        rx = 1'b0;
        clks(4);
        rx = 1'b1;
        clks(40);
        check("t2_glitch_no_byte", 32'(nbytes - nb0), 32'd0);
        check("t2_glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        clks(4);
        check("t2_valid", 32'(valid), 32'd1);
        check("t2_data", 32'(data), 32'h3C);
        accept_one();

        // 3: bad stop bit followed by a long break
        nb0 = nbytes;
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        clks(40 * BIT_CLKS);
        check("t3_one_fe", 32'(fe_cnt - fe0), 32'd1);
        check("t3_no_byte_in_break", 32'(nbytes - nb0), 32'd0);
        check("t3_valid_low", 32'(valid), 32'd0);
        rx = 1'b1;
        clks(2 * BIT_CLKS);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        clks(4);
        check("t3_valid", 32'(valid), 32'd1);
        check("t3_data", 32'(data), 32'h81);
        check("t3_fe_total", 32'(fe_cnt - fe0), 32'd1);
        accept_one();
        clks(BIT_CLKS);

        // 4: overrun when the second byte arrives unaccepted
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        clks(4);
        check("t4_valid", 32'(valid), 32'd1);
        check("t4_data_kept", 32'(data), 32'h11);
        check("t4_one_ov", 32'(ov_cnt - ov0), 32'd1);
        accept_one();
        clks(BIT_CLKS);

        // 5: ready held high, three back-to-back frames
        nb0 = nbytes;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        vc0 = vcycles;
        ready = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h5A);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h5A, 1'b1);
        clks(20);
        ready = 1'b0;
        check("t5_three_bytes", 32'(nbytes - nb0), 32'd3);
        check("t5_one_cycle_each", 32'(vcycles - vc0), 32'd3);
        check("t5_no_fe", 32'(fe_cnt - fe0), 32'd0);
        check("t5_no_ov", 32'(ov_cnt - ov0), 32'd0);
        check("t5_valid_low", 32'(valid), 32'd0);

        // 6: reset in the middle of bit 4 of 0xC3
        nb0 = nbytes;
        fe0 = fe_cnt;
        c3 = 8'hC3;
        rx = 1'b0;
        clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = c3[i];
            clks(BIT_CLKS);
        end
        rx = c3[4];
        clks(8);
        reset = 1'b1;
        clks(2);
        check("t6_reset_valid", 32'(valid), 32'd0);
        check("t6_reset_data", 32'(data), 32'h00);
        check("t6_reset_fe", 32'(frame_error), 32'd0);
        check("t6_reset_ov", 32'(overrun), 32'd0);
        reset = 1'b0;
        clks(6);
        for (int i = 5; i < 8; i++) begin
            rx = c3[i];
            clks(BIT_CLKS);
        end
        rx = 1'b1;
        clks(3 * BIT_CLKS);
        check("t6_no_partial_byte", 32'(nbytes - nb0), 32'd0);
        check("t6_no_fe", 32'(fe_cnt - fe0), 32'd0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        clks(4);
        check("t6_valid", 32'(valid), 32'd1);
        check("t6_data", 32'(data), 32'h7E);
        accept_one();
        clks(4);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
